// File: rtl/riscv_fetch_unit.sv
// ============================================================================
// riscv_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the RV32I five-stage pipeline. It sits directly
// upstream of decode and is steered by the hazard unit's stall/flush outputs.
//
// Responsibilities:
//   - Owns the fetch PC (pc_f) and issues one outstanding request at a time
//     to instruction memory, which may answer after any number of cycles.
//   - Loads the IF/ID pipeline register (instruction, PC, PC+4, valid).
//   - Takes branch/jump redirects from execute. A response that is still in
//     flight when the redirect arrives is stale and gets discarded.
//   - Holds a response that arrives while decode is stalled in a one-entry
//     skid buffer, so that no fetched instruction is lost.
//
// Parameters:
//   RESET_PC   first fetch address after reset (word aligned)
//   NOP_INSTR  instruction loaded into IF/ID as a bubble (addi x0,x0,0)
//
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst          synchronous, active-high reset
//   i_stall_f      hold the fetch PC and issue no new request
//   i_stall_d      hold the IF/ID register
//   i_flush_d      clear IF/ID to a bubble and drop the skid buffer
//   i_pc_src_e     redirect taken in execute
//   i_pc_target_e  redirect address (bits [1:0] are ignored)
//   o_imem_req     fetch request, combinational from state and inputs
//   o_imem_addr    request address, always word aligned
//   i_imem_ready   memory accepts the request when req && ready
//   i_imem_rvalid  response valid, at least one cycle after acceptance
//   i_imem_rdata   response instruction word
//   o_instr_d      IF/ID instruction
//   o_pc_d         IF/ID PC
//   o_pc_plus4_d   IF/ID PC+4
//   o_valid_d      IF/ID holds a real instruction (0 = bubble)
// ============================================================================
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_pc_src_e,
    input  logic [31:0] i_pc_target_e,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d
);

    // Fetch sequencer states:
    //   ST_IDLE  only after reset; ignores any response still in flight
    //   ST_REQ   ready to issue a request at pc_f
    //   ST_WAIT  one request outstanding, waiting for its response
    //   ST_KILL  one request outstanding whose response is stale
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_KILL
    } fetch_state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_f;
    logic [31:0] pc_out;

    logic        buf_vld;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        issue_ok;
    logic        resp_live;
    logic        resp_to_ifid;
    logic        resp_to_buf;
    logic        buf_drain;
    logic        accept;

    // The address bus always shows pc_f; the mask guarantees word alignment
    // even if a misaligned RESET_PC were configured.
    assign o_imem_addr = pc_f & WORD_MASK;

    // Request and response steering.
    // A new request is only allowed when fetch is not stalled, the skid
    // buffer is empty (so a second response always has somewhere to go) and
    // no redirect is pending this cycle.
    // A response is "live" only in ST_WAIT and only if no redirect arrives in
    // the same cycle; a redirect makes the in-flight response stale.
    // A live response goes straight to IF/ID when decode can take it,
    // otherwise it parks in the skid buffer. A flush in the same cycle kills
    // the response instead of parking it, since flush also empties the buffer.
    // In ST_WAIT a back-to-back request is allowed only when the current
    // response is consumed directly by IF/ID, keeping one request in flight.
    always_comb begin
        issue_ok     = 1'b0;
        resp_live    = 1'b0;
        resp_to_ifid = 1'b0;
        resp_to_buf  = 1'b0;
        o_imem_req   = 1'b0;

        issue_ok     = !i_stall_f && !buf_vld && !i_pc_src_e;
        resp_live    = (state_q == ST_WAIT) && i_imem_rvalid && !i_pc_src_e;
        resp_to_ifid = resp_live && !i_stall_d && !buf_vld;
        resp_to_buf  = resp_live && !resp_to_ifid && !i_flush_d;

        case (state_q)
            ST_REQ:  o_imem_req = issue_ok;
            ST_WAIT: o_imem_req = resp_to_ifid && issue_ok;
            default: o_imem_req = 1'b0;
        endcase
    end

    assign accept    = o_imem_req && i_imem_ready;
    assign buf_drain = buf_vld && !i_stall_d && !i_flush_d;

    // Next-state logic for the fetch sequencer.
    // ST_KILL leaves only when the stale response shows up, whether or not a
    // further redirect arrives meanwhile (the redirect only moves pc_f), so
    // the unit can never wait for a response that will not come.
    always_comb begin
        state_d = state_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!i_pc_src_e && accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_pc_src_e) begin
                    state_d = i_imem_rvalid ? ST_REQ : ST_KILL;
                end else if (i_imem_rvalid) begin
                    state_d = accept ? ST_WAIT : ST_REQ;
                end
            end
            ST_KILL: begin
                if (i_imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus the two fetch PCs.
    // pc_f is the next address to request; pc_out remembers the address of
    // the request in flight so its response can be tagged with the right PC.
    // A redirect wins over everything, including i_stall_f.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_f    <= RESET_PC & WORD_MASK;
            pc_out  <= RESET_PC & WORD_MASK;
        end else begin
            state_q <= state_d;
            if (i_pc_src_e) begin
                pc_f <= i_pc_target_e & WORD_MASK;
            end else if (accept) begin
                pc_f <= pc_f + 32'd4;
            end
            if (accept) begin
                pc_out <= pc_f;
            end
        end
    end

    // One-entry skid buffer.
    // Captures a response that decode cannot accept this cycle. It is emptied
    // by a redirect (the entry is on the wrong path), by a flush, or by
    // draining into IF/ID once decode is neither stalled nor flushed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_vld   <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0000_0000;
        end else begin
            if (i_pc_src_e || i_flush_d) begin
                buf_vld <= 1'b0;
            end else if (resp_to_buf) begin
                buf_vld <= 1'b1;
            end else if (buf_drain) begin
                buf_vld <= 1'b0;
            end
            if (resp_to_buf) begin
                buf_instr <= i_imem_rdata;
                buf_pc    <= pc_out;
            end
        end
    end

    // IF/ID pipeline register.
    // Priority: flush, then stall (hold), then the buffered instruction, then
    // a live response, otherwise a bubble. Bubbles keep the previous PC
    // fields so decode never sees a spurious PC change on an invalid slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_instr_d    <= NOP_INSTR;
            o_pc_d       <= 32'h0000_0000;
            o_pc_plus4_d <= 32'h0000_0004;
            o_valid_d    <= 1'b0;
        end else if (i_flush_d) begin
            o_instr_d <= NOP_INSTR;
            o_valid_d <= 1'b0;
        end else if (i_stall_d) begin
            o_instr_d    <= o_instr_d;
            o_pc_d       <= o_pc_d;
            o_pc_plus4_d <= o_pc_plus4_d;
            o_valid_d    <= o_valid_d;
        end else if (buf_vld) begin
            o_instr_d    <= buf_instr;
            o_pc_d       <= buf_pc;
            o_pc_plus4_d <= buf_pc + 32'd4;
            o_valid_d    <= 1'b1;
        end else if (resp_to_ifid) begin
            o_instr_d    <= i_imem_rdata;
            o_pc_d       <= pc_out;
            o_pc_plus4_d <= pc_out + 32'd4;
            o_valid_d    <= 1'b1;
        end else begin
            o_instr_d <= NOP_INSTR;
            o_valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// ============================================================================
// tb_riscv_fetch_unit
// ----------------------------------------------------------------------------
// Directed bench for riscv_fetch_unit. A small instruction-memory model
// answers every accepted request after mem_lat cycles with
// rdata = addr ^ 32'hA5A5_0000, so the expected instruction for any PC is
// known in advance. Each step drives the inputs for one cycle at the falling
// edge and then compares outputs against hand-computed values.
// ============================================================================
module tb_riscv_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall_f;
    logic        i_stall_d;
    logic        i_flush_d;
    logic        i_pc_src_e;
    logic [31:0] i_pc_target_e;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr_d;
    logic [31:0] o_pc_d;
    logic [31:0] o_pc_plus4_d;
    logic        o_valid_d;

    int check_count = 0;
    int error_count = 0;

    // Memory model state
    int          mem_lat  = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    riscv_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall_f     (i_stall_f),
        .i_stall_d     (i_stall_d),
        .i_flush_d     (i_flush_d),
        .i_pc_src_e    (i_pc_src_e),
        .i_pc_target_e (i_pc_target_e),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_d     (o_instr_d),
        .o_pc_d        (o_pc_d),
        .o_pc_plus4_d  (o_pc_plus4_d),
        .o_valid_d     (o_valid_d)
    );

    always #5 i_clk = ~i_clk;

    // Instruction memory: one request in flight, response mem_lat cycles
    // after acceptance. It keeps running through DUT reset so a stale
    // response can reach the DUT after reset.
    assign i_imem_rvalid = mem_busy && (mem_cnt == 0);
    assign i_imem_rdata  = mem_addr ^ KEY;

    always @(posedge i_clk) begin
        if (i_imem_rvalid) begin
            mem_busy <= 1'b0;
        end
        if (o_imem_req && i_imem_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_addr <= o_imem_addr;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Drive all control inputs for the coming cycle at the falling edge and
    // let combinational outputs settle before any check.
    task automatic applyStimulus(input logic rst, input logic stall_f,
                                 input logic stall_d, input logic flush_d,
                                 input logic pc_src, input logic [31:0] target);
        @(negedge i_clk);
        i_rst         = rst;
        i_stall_f     = stall_f;
        i_stall_d     = stall_d;
        i_flush_d     = flush_d;
        i_pc_src_e    = pc_src;
        i_pc_target_e = target;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected)
        else begin
            error_count++;
            $error("[TB] FAIL %s: observed 32'h%08h expected 32'h%08h",
                   tag, observed, expected);
        end
    endtask

    // Fetch-side check; the address only matters when a request is expected.
    task automatic checkFetch(input string tag, input logic req,
                              input logic [31:0] addr);
        checkOutput({tag, ".req"}, {31'b0, o_imem_req}, {31'b0, req});
        if (req) begin
            checkOutput({tag, ".addr"}, o_imem_addr, addr);
        end
    endtask

    // Full IF/ID check; expected instruction of a valid slot is pc ^ KEY.
    task automatic checkDecode(input string tag, input logic valid,
                               input logic [31:0] pc);
        logic [31:0] exp_instr;
        exp_instr = valid ? (pc ^ KEY) : NOP;
        checkOutput({tag, ".valid"}, {31'b0, o_valid_d}, {31'b0, valid});
        checkOutput({tag, ".instr"}, o_instr_d, exp_instr);
        checkOutput({tag, ".pc"}, o_pc_d, pc);
        checkOutput({tag, ".pc4"}, o_pc_plus4_d, pc + 32'd4);
    endtask

    task automatic checkValid(input string tag, input logic valid);
        checkOutput({tag, ".valid"}, {31'b0, o_valid_d}, {31'b0, valid});
    endtask

    initial begin
        i_rst         = 1'b1;
        i_stall_f     = 1'b0;
        i_stall_d     = 1'b0;
        i_flush_d     = 1'b0;
        i_pc_src_e    = 1'b0;
        i_pc_target_e = 32'h0;
        i_imem_ready  = 1'b1;
        $display("[TB] start");

        // Reset values
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        checkFetch("rst", 0, 32'h0);
        checkDecode("rst", 0, 32'h0);

        // Zero-wait stream: requests 0,4,8 on cycles 1..3, decode 3..5
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c0_idle", 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c1", 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c2", 1, 32'h4);
        checkValid("c2", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c3", 1, 32'h8);
        checkDecode("c3", 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c4", 1, 32'h4);

        // Reset mid-transaction with latency 3; stale response lands in IDLE
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        mem_lat = 3;
        checkDecode("c5", 1, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        checkDecode("rst2", 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c8_idle", 0, 32'h0);

        // k=3: one request in flight, one valid instruction per three cycles
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c9", 1, 32'h0);
        checkValid("c9_stale", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c10", 0, 32'h0);
        checkValid("c10_stale", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c11", 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c12", 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c13", 0, 32'h0);
        checkDecode("c13", 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c14", 0, 32'h0);
        checkValid("c14", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c15", 1, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c16", 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkValid("c17", 0);

        // Stall F and D for two cycles while the response for 0x8 arrives
        applyStimulus(0, 1, 1, 0, 0, 32'h0);
        checkFetch("c18_stall", 0, 32'h0);
        checkDecode("c18_hold", 0, 32'h4);
        applyStimulus(0, 1, 1, 0, 0, 32'h0);
        checkFetch("c19_stall", 0, 32'h0);
        checkDecode("c19_hold", 0, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c20_bufwait", 0, 32'h0);
        checkValid("c20", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c21_drain", 1, 32'h8);
        checkFetch("c21_resume", 1, 32'hC);

        // Redirect to 0x100 while waiting: response for 0xC is discarded
        applyStimulus(0, 0, 0, 0, 1, 32'h100);
        checkFetch("c22_redir", 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c23_kill", 0, 32'h0);
        checkOutput("c23_kill.addr", o_imem_addr, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c24_kill", 0, 32'h0);
        checkValid("c24", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c25", 1, 32'h100);
        checkValid("c25_nostale", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkValid("c26_nostale", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkValid("c27_nostale", 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        mem_lat = 1;
        checkFetch("c28", 1, 32'h104);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c29_target", 1, 32'h100);
        checkFetch("c29", 1, 32'h108);

        // Redirect with stall_f, plus flush_d with stall_d; misaligned target
        applyStimulus(0, 1, 1, 1, 1, 32'hFFFF_FFFF);
        checkFetch("c30_redir", 0, 32'h0);
        checkDecode("c30", 1, 32'h104);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c31_flush", 0, 32'h104);
        checkFetch("c31", 1, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkFetch("c32_wrap", 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c33_top", 1, 32'hFFFF_FFFC);
        checkOutput("c33_pc4wrap", o_pc_plus4_d, 32'h0);
        checkFetch("c33", 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkDecode("c34", 1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 check_count, error_count);
        $finish;
    end

endmodule
